// File: rtl/user_request_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS request/ack clients onto one
// single-outstanding memory bridge (enable pulse out, ready pulse back).
module user_request_arbiter #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned USER_DATA_WIDTH = 128,
  parameter int unsigned USER_ADDR_WIDTH = 32,
  parameter int unsigned STARTUP_CYCLES  = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [NUM_PORTS-1:0]                   req_valid,
  input  logic [NUM_PORTS-1:0]                   req_write,
  input  logic [NUM_PORTS*USER_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*USER_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]                   req_ack,
  output logic [USER_DATA_WIDTH-1:0]             req_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]           grant_idx,
  output logic [USER_ADDR_WIDTH-1:0]             mem_addr,
  output logic                                   mem_read_enable,
  output logic                                   mem_write_enable,
  output logic [USER_DATA_WIDTH-1:0]             mem_write_data,
  input  logic [USER_DATA_WIDTH-1:0]             mem_read_data,
  input  logic                                   mem_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           init_cnt, init_cnt_nxt;
  logic [IDX_W-1:0]           rr_ptr, rr_ptr_nxt;
  logic                       wr_flag, wr_flag_nxt;
  logic [IDX_W-1:0]           grant_idx_nxt;
  logic [USER_ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [USER_DATA_WIDTH-1:0] mem_write_data_nxt;
  logic [USER_DATA_WIDTH-1:0] req_rdata_nxt;
  logic [NUM_PORTS-1:0]       req_ack_nxt;
  logic                       mem_read_enable_nxt;
  logic                       mem_write_enable_nxt;

  logic                       init_done;
  logic                       win_found;
  logic [IDX_W-1:0]           win_idx;
  logic [IDX_W-1:0]           cand;

  logic [USER_ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [USER_DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*USER_ADDR_WIDTH +: USER_ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*USER_DATA_WIDTH +: USER_DATA_WIDTH];
  end

  assign init_done = (32'(init_cnt) + 32'd1 >= STARTUP_CYCLES);

  // First requesting port at or above rr_ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % int'(NUM_PORTS));
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state            <= INIT;
      init_cnt         <= '0;
      rr_ptr           <= '0;
      wr_flag          <= 1'b0;
      grant_idx        <= '0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      req_rdata        <= '0;
      req_ack          <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
    end else begin
      state            <= state_nxt;
      init_cnt         <= init_cnt_nxt;
      rr_ptr           <= rr_ptr_nxt;
      wr_flag          <= wr_flag_nxt;
      grant_idx        <= grant_idx_nxt;
      mem_addr         <= mem_addr_nxt;
      mem_write_data   <= mem_write_data_nxt;
      req_rdata        <= req_rdata_nxt;
      req_ack          <= req_ack_nxt;
      mem_read_enable  <= mem_read_enable_nxt;
      mem_write_enable <= mem_write_enable_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_done) state_nxt = IDLE;
      IDLE:    if (win_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Next values of the registered outputs and datapath; enables and ack pulse
  always_comb begin
    init_cnt_nxt         = init_cnt;
    rr_ptr_nxt           = rr_ptr;
    wr_flag_nxt          = wr_flag;
    grant_idx_nxt        = grant_idx;
    mem_addr_nxt         = mem_addr;
    mem_write_data_nxt   = mem_write_data;
    req_rdata_nxt        = req_rdata;
    req_ack_nxt          = '0;
    mem_read_enable_nxt  = 1'b0;
    mem_write_enable_nxt = 1'b0;
    case (state)
      INIT: init_cnt_nxt = init_cnt + CNT_W'(1);
      IDLE: begin
        if (win_found) begin
          grant_idx_nxt        = win_idx;
          mem_addr_nxt         = addr_arr[win_idx];
          mem_write_data_nxt   = wdata_arr[win_idx];
          wr_flag_nxt          = req_write[win_idx];
          mem_write_enable_nxt = req_write[win_idx];
          mem_read_enable_nxt  = !req_write[win_idx];
          rr_ptr_nxt           = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          if (!wr_flag) req_rdata_nxt = mem_read_data;
          req_ack_nxt[grant_idx] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
